// File: rtl/fifo_rd_stream.sv
// Read-side drain of the async FIFO into a registered valid/ready stream with a
// 2-entry skid buffer and fixed-length packet framing. Optional FIFO_RD_STAT_EN adds stat counters.
module fifo_rd_stream #(
  parameter int DSIZE   = 8,
  parameter int PKT_LEN = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [DSIZE-1:0] fifo_rdata,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready
`ifdef FIFO_RD_STAT_EN
  ,
  output logic [31:0]      stat_beats,
  output logic [31:0]      stat_stall
`endif
);

  localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(PKT_LEN - 1);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [DSIZE-1:0] main_q, main_nxt;
  logic [DSIZE-1:0] skid_q, skid_nxt;
  logic [CW-1:0]    beat_cnt;
  logic             push, pop;

  // Pop strobe uses registered occupancy only, so m_ready never reaches rinc.
  assign fifo_rinc = !rrst && !fifo_rempty && (state != FULL);
  assign push      = fifo_rinc;
  assign m_valid   = (state != EMPTY);
  assign pop       = m_valid && m_ready;
  assign m_data    = main_q;
  assign m_last    = m_valid && (beat_cnt == BEAT_LAST);

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          main_nxt  = fifo_rdata;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_nxt = FULL;
          skid_nxt  = fifo_rdata;
        end else if (push && pop) begin
          main_nxt  = fifo_rdata;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt = ONE;
          main_nxt  = skid_q;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  // Packet position advances on accepted beats only; FIFO underflow just stalls it.
  always_ff @(posedge rclk) begin
    if (rrst)
      beat_cnt <= '0;
    else if (pop)
      beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;
  end

`ifdef FIFO_RD_STAT_EN
  always_ff @(posedge rclk) begin
    if (rrst) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      if (pop && stat_beats != 32'hFFFF_FFFF)
        stat_beats <= stat_beats + 32'd1;
      if (m_valid && !m_ready && stat_stall != 32'hFFFF_FFFF)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue models the FIFO, a negedge monitor
// checks every accepted beat (data + m_last) against expectations pushed at load time.
module tb_fifo_rd_stream;
  localparam int DSIZE   = 8;
  localparam int PKT_LEN = 16;

  logic             rclk = 1'b0;
  logic             rrst = 1'b1;
  logic [DSIZE-1:0] fifo_rdata = '0;
  logic             fifo_rempty = 1'b1;
  logic             fifo_rinc;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_last;
  logic             m_ready = 1'b0;
`ifdef FIFO_RD_STAT_EN
  logic [31:0]      stat_beats, stat_stall;
`endif

  fifo_rd_stream #(.DSIZE(DSIZE), .PKT_LEN(PKT_LEN)) dut (
    .rclk(rclk), .rrst(rrst),
    .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rinc(fifo_rinc),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
`ifdef FIFO_RD_STAT_EN
    , .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;
  logic [DSIZE-1:0] fq[$];   // FIFO contents
  logic [DSIZE:0]   sb[$];   // expected {last, data}
  int pos = 0;               // expected packet position of next loaded beat
  logic rinc_s = 1'b0;
  int run = 0, max_run = 0;
  logic [DSIZE:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: pop on the strobe seen mid-cycle, then present the new head.
  always @(posedge rclk) begin
    if (rinc_s) begin
      if (fq.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_empty: rinc with empty FIFO at %0t", $time);
      end else void'(fq.pop_front());
    end
    #2;
    fifo_rempty = (fq.size() == 0);
    fifo_rdata  = (fq.size() != 0) ? fq[0] : '0;
  end

  always @(negedge rclk) begin
    if (m_valid && m_ready && !rrst) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got %0h expected none", m_data);
      end else begin
        e = sb.pop_front();
        chk("beat_data", {24'd0, m_data}, {24'd0, e[DSIZE-1:0]});
        chk("beat_last", {31'd0, m_last}, {31'd0, e[DSIZE]});
      end
    end
    rinc_s = fifo_rinc;
    run = fifo_rinc ? run + 1 : 0;
    if (run > max_run) max_run = run;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic load(input int n, input logic [DSIZE-1:0] base);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + DSIZE'(i));
      sb.push_back({(pos == PKT_LEN - 1), base + DSIZE'(i)});
      pos = (pos + 1) % PKT_LEN;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge rclk);
      n++;
    end
    #1;
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    // 1: reset held with FIFO nonempty
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    tick(2);
    chk("rst_rinc", {31'd0, fifo_rinc}, 0);
    chk("rst_valid", {31'd0, m_valid}, 0);
    chk("rst_data", {24'd0, m_data}, 0);
    chk("rst_last", {31'd0, m_last}, 0);
`ifdef FIFO_RD_STAT_EN
    chk("rst_stat_beats", stat_beats, 0);
`endif
    fq.delete();
    rrst = 1'b0;
    tick(2);

    // 2: 32 back-to-back beats, m_last on 0x10 and 0x20
    m_ready = 1'b1;
    max_run = 0;
    load(32, 8'h01);
    wait_drain(100);
    chk("rinc_run", max_run, 32);

    // 3: backpressure right after first beat
    m_ready = 1'b0;
    load(16, 8'h01);
    tick(5);
    chk("bp_rinc", {31'd0, fifo_rinc}, 0);
    chk("bp_valid", {31'd0, m_valid}, 1);
    chk("bp_data", {24'd0, m_data}, 32'h01);
    chk("bp_fifo_left", fq.size(), 14);
    tick(2);
    chk("bp_data_hold", {24'd0, m_data}, 32'h01);
    m_ready = 1'b1;
    wait_drain(100);

    // 4: underflow after 7 beats, resume with rest of the packet
    load(7, 8'h60);
    wait_drain(100);
    tick(5);
    chk("uf_valid", {31'd0, m_valid}, 0);
    chk("uf_rinc", {31'd0, fifo_rinc}, 0);
    tick(5);
    load(9, 8'h67);    // last expected on 0x6F
    wait_drain(100);

    // 5: reset mid-packet with two beats buffered
    load(6, 8'h80);
    wait_drain(100);
    m_ready = 1'b0;
    fq.push_back(8'h90); fq.push_back(8'h91); fq.push_back(8'h92);
    tick(5);
    chk("mr_rinc_full", {31'd0, fifo_rinc}, 0);
    chk("mr_fifo_left", fq.size(), 1);
    rrst = 1'b1;
    tick(1);
    chk("mr_valid", {31'd0, m_valid}, 0);
    chk("mr_rinc", {31'd0, fifo_rinc}, 0);
    rrst = 1'b0;
    fq.delete();
    pos = 0;
    tick(1);
    m_ready = 1'b1;
    load(16, 8'hC0);   // last expected on 0xCF
    wait_drain(100);

`ifdef FIFO_RD_STAT_EN
    // 6: 20 pops with 7 stall cycles
    rrst = 1'b1;
    tick(1);
    rrst = 1'b0;
    pos = 0;
    m_ready = 1'b0;
    load(20, 8'h20);
    @(posedge rclk);
    repeat (7) @(posedge rclk);
    #1;
    m_ready = 1'b1;
    wait_drain(100);
    tick(1);
    chk("stat_beats", stat_beats, 20);
    chk("stat_stall", stat_stall, 7);
`endif

    tick(3);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
